imem_loader: RTL and testbench

Program loader and fetch-hold controller for the instruction memory. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words and sequences one-cycle writes into the instruction memory at word-aligned byte addresses. It holds the CPU fetch path in stall while a program is loaded, and from reset until the first load completes. It sits between the external program source (UART/testbench) and the instruction memory's write port, alongside the PC/fetch logic.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_word_assembler.sv | 38 +++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: memory size and
// FSM state encodings, so the loader and the instruction memory agree.
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 32;
    localparam int IMEM_ADDR_W = 5;

    typedef enum logic [1:0] {
        IMEM_IDLE   = 2'd0,
        IMEM_LOAD   = 2'd1,
        IMEM_WRITE  = 2'd2,
        IMEM_FINISH = 2'd3
    } imem_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian bytes into one 32-bit instruction word.
// The 2-bit lane counter wraps 3->0 on its own at each word boundary.
module imem_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] byte_cnt;

    // Completing the fourth lane is signalled in the same cycle as its accept,
    // so the FSM can move to WRITE on that edge.
    assign full = accept & (byte_cnt == 2'd3);

    // Place each accepted byte into the lane selected by the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (accept) begin
            case (byte_cnt)
                2'd0: word[7:0]   <= byte_data;
                2'd1: word[15:8]  <= byte_data;
                2'd2: word[23:16] <= byte_data;
                2'd3: word[31:24] <= byte_data;
                default: word[7:0] <= byte_data;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader and fetch-hold controller. Streams bytes into 32-bit words,
// issues one-cycle writes to the instruction memory, and keeps the CPU
// stalled until a first program has been loaded and while any load runs.
//
// state   | meaning
// IDLE    | waiting for start; rejects out-of-range word counts
// LOAD    | accepting bytes for the current word
// WRITE   | one-cycle write strobe of the assembled word
// FINISH  | one-cycle done pulse, marks the memory as loaded
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_write_enable,
    output logic [31:0]       mem_write_address,
    output logic [31:0]       mem_write_data,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

    imem_state_t       state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   index;
    logic [ADDR_W:0]   index_next;
    logic              loaded;
    logic              start_ok;
    logic              accept;
    logic              clear;
    logic              full;
    logic [31:0]       word;

    assign start_ok   = (word_count != '0) && (word_count <= MAX_COUNT);
    assign byte_ready = (state == IMEM_LOAD);
    assign accept     = byte_valid & byte_ready;
    assign clear      = (state == IMEM_IDLE) & start & start_ok;
    assign index_next = index + ONE;

    imem_word_assembler u_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (word),
        .full      (full)
    );

    // Sequencing FSM with word index, latched count, loaded flag and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IMEM_IDLE;
            count  <= '0;
            index  <= '0;
            loaded <= 1'b0;
            error  <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                IMEM_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            count <= word_count;
                            index <= '0;
                            state <= IMEM_LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                IMEM_LOAD: begin
                    if (full) begin
                        state <= IMEM_WRITE;
                    end
                end
                IMEM_WRITE: begin
                    index <= index_next;
                    state <= (index_next == count) ? IMEM_FINISH : IMEM_LOAD;
                end
                IMEM_FINISH: begin
                    loaded <= 1'b1;
                    state  <= IMEM_IDLE;
                end
                default: state <= IMEM_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; address/data read zero outside WRITE.
    always_comb begin
        busy              = (state != IMEM_IDLE);
        mem_write_enable  = (state == IMEM_WRITE);
        done              = (state == IMEM_FINISH);
        cpu_stall         = !loaded | busy;
        mem_write_address = '0;
        mem_write_data    = '0;
        if (state == IMEM_WRITE) begin
            mem_write_address = {{(32 - ADDR_W - 2){1'b0}}, index[ADDR_W-1:0], 2'b00};
            mem_write_data    = word;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes,
// a monitor pops and compares on each write strobe.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        cpu_stall;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    logic [63:0] exp_q[$];

    imem_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .word_count        (word_count),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .byte_ready        (byte_ready),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .cpu_stall         (cpu_stall),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && mem_write_enable) begin
            logic [63:0] e;
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe got addr %h data %h expected none",
                         mem_write_address, mem_write_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", mem_write_address, e[63:32]);
                check("wr_data", mem_write_data, e[31:0]);
            end
        end
    end

    // All tasks enter and leave just after a rising edge.
    task automatic do_start(input logic [5:0] wc);
        start = 1'b1;
        word_count = wc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        byte_valid = 1'b1;
        byte_data = b;
        n = 0;
        @(negedge clk);
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout got ready 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [31:0] idx, input logic [31:0] w, input int gap, input bit expect_write);
        if (expect_write) exp_q.push_back({idx << 2, w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        byte_valid = 1'b0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_pulse", {31'd0, done}, 32'd1);
        check("stall_at_done", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk); #1;
        check("done_low", {31'd0, done}, 32'd0);
        check("stall_released", {31'd0, cpu_stall}, 32'd0);
        check("busy_low", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, {31'd0, cpu_stall}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, mem_write_enable}, 32'd0);
        check({tag, "_addr"}, mem_write_address, 32'd0);
        check({tag, "_data"}, mem_write_data, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        int base_strobes;
        rst_n = 1'b0;
        start = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post_rst");

        // Zero-length load is rejected with a one-cycle error pulse.
        do_start(6'd0);
        check("err_wc0", {31'd0, error}, 32'd1);
        check("err_wc0_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("err_wc0_clear", {31'd0, error}, 32'd0);

        // Single word, back-to-back bytes.
        do_start(6'd1);
        check("start_ready", {31'd0, byte_ready}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        send_word(0, 32'h0050_0093, 0, 1'b1);
        check("write_cycle_we", {31'd0, mem_write_enable}, 32'd1);
        check("write_cycle_ready", {31'd0, byte_ready}, 32'd0);
        wait_done();

        // Oversized load is rejected.
        do_start(6'd33);
        check("err_wc33", {31'd0, error}, 32'd1);
        check("err_wc33_busy", {31'd0, busy}, 32'd0);

        // Full 32-word load with a gap before every byte.
        base_strobes = strobes;
        do_start(6'd32);
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b0;
            b0 = 8'(8'h10 + 4 * i);
            send_word(i, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 1, 1'b1);
        end
        wait_done();
        repeat (3) @(posedge clk); #1;
        check("strobes_32", strobes - base_strobes, 32);

        // Start during an active load is ignored: two words still written.
        base_strobes = strobes;
        do_start(6'd2);
        send_word(0, 32'hA1B2_C3D4, 0, 1'b1);
        byte_valid = 1'b0;
        @(posedge clk); #1;
        do_start(6'd1);
        check("busy_start_no_err", {31'd0, error}, 32'd0);
        check("busy_start_busy", {31'd0, busy}, 32'd1);
        send_word(1, 32'h1122_3344, 0, 1'b1);
        wait_done();
        check("strobes_ignored_start", strobes - base_strobes, 2);

        // Reset after six bytes of a two-word load.
        base_strobes = strobes;
        do_start(6'd2);
        send_word(0, 32'hDEAD_BEEF, 0, 1'b1);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("strobes_mid_rst", strobes - base_strobes, 1);
        check("stall_after_rst", {31'd0, cpu_stall}, 32'd1);

        // Fresh load after reset starts again at address 0.
        do_start(6'd1);
        send_word(0, 32'hCAFE_F00D, 0, 1'b1);
        wait_done();

        // Reload re-stalls the CPU while busy, overwrites, then releases.
        do_start(6'd2);
        check("reload_stall", {31'd0, cpu_stall}, 32'd1);
        send_word(0, 32'h0123_4567, 0, 1'b1);
        send_word(1, 32'h89AB_CDEF, 2, 1'b1);
        wait_done();
        repeat (3) @(posedge clk); #1;
        check("loaded_kept", {31'd0, cpu_stall}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
